// File: rtl/rs_slot_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_slot_scheduler_if
// Description : Bundles the signals between the dual-issue ALU reservation
//               station slot scheduler and its neighbours. These are the
//               decode allocation lanes, the writeback tag broadcast, the two
//               ALU issue ports and the occupancy status.
//   master : decode / writeback / ALU side (drives requests, stalls, tags)
//   slave  : the scheduler (drives alloc_ok, slot IDs, issue selects, status)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_slot_scheduler_if #(
  parameter int TAG_W = 4
);
  // global enable and mispredict flush
  logic             rdy;
  logic             flush;

  // allocation lane 0
  logic             a0_valid;
  logic [TAG_W-1:0] a0_s1_tag;
  logic [TAG_W-1:0] a0_s2_tag;
  logic             a0_s1_rdy;
  logic             a0_s2_rdy;

  // allocation lane 1 (only meaningful together with lane 0)
  logic             a1_valid;
  logic [TAG_W-1:0] a1_s1_tag;
  logic [TAG_W-1:0] a1_s2_tag;
  logic             a1_s1_rdy;
  logic             a1_s2_rdy;

  // allocation response
  logic             alloc_ok;
  logic [2:0]       alloc_slot0;
  logic [2:0]       alloc_slot1;

  // writeback broadcast
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;

  // issue ports
  logic             iss0_valid;
  logic             iss1_valid;
  logic [2:0]       iss0_slot;
  logic [2:0]       iss1_slot;
  logic             iss0_stall;
  logic             iss1_stall;

  // occupancy status
  logic [2:0]       free_cnt;
  logic             full;

  modport master (
    output rdy, flush,
    output a0_valid, a0_s1_tag, a0_s2_tag, a0_s1_rdy, a0_s2_rdy,
    output a1_valid, a1_s1_tag, a1_s2_tag, a1_s1_rdy, a1_s2_rdy,
    input  alloc_ok, alloc_slot0, alloc_slot1,
    output wb_valid, wb_tag,
    input  iss0_valid, iss1_valid, iss0_slot, iss1_slot,
    output iss0_stall, iss1_stall,
    input  free_cnt, full
  );

  modport slave (
    input  rdy, flush,
    input  a0_valid, a0_s1_tag, a0_s2_tag, a0_s1_rdy, a0_s2_rdy,
    input  a1_valid, a1_s1_tag, a1_s2_tag, a1_s1_rdy, a1_s2_rdy,
    output alloc_ok, alloc_slot0, alloc_slot1,
    input  wb_valid, wb_tag,
    output iss0_valid, iss1_valid, iss0_slot, iss1_slot,
    input  iss0_stall, iss1_stall,
    output free_cnt, full
  );
endinterface
`default_nettype wire

// File: rtl/rs_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rs_slot_scheduler
// Description : Six-entry reservation-station slot scheduler. Tracks per-slot
//               busy / operand-ready state, hands up to two free slot IDs to
//               decode per cycle, wakes operands on writeback tag match and
//               picks up to two ready slots (lowest index first) for the two
//               ALU issue ports. Slot ID 3'b111 means "no slot".
//   clk : clock
//   rst : synchronous active-high reset
//   bus : rs_slot_scheduler_if.slave (allocation lanes, writeback, issue
//         ports, free_cnt / full status)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_slot_scheduler #(
  parameter int N_ENTRY = 6,
  parameter int TAG_W   = 4
) (
  input logic                clk,
  input logic                rst,
  rs_slot_scheduler_if.slave bus
);

  localparam logic [2:0] c_no_slot = 3'd7;

  // per-slot registered state
  logic [N_ENTRY-1:0] r_busy;
  logic [N_ENTRY-1:0] r_s1_rdy;
  logic [N_ENTRY-1:0] r_s2_rdy;
  logic [TAG_W-1:0]   r_s1_tag [N_ENTRY];
  logic [TAG_W-1:0]   r_s2_tag [N_ENTRY];

  logic [N_ENTRY-1:0] w_free;
  logic [N_ENTRY-1:0] w_ready;
  logic [2:0]         w_alloc_slot0;
  logic [2:0]         w_alloc_slot1;
  logic [2:0]         w_iss0_slot;
  logic [2:0]         w_iss1_slot;
  logic [2:0]         w_free_cnt;
  logic [1:0]         w_need;
  logic               w_alloc_ok;
  logic               w_iss0_valid;
  logic               w_iss1_valid;
  logic               w_leave0;
  logic               w_leave1;
  logic               w_wr0;
  logic               w_wr1;
  logic               w_a0_s1_rdy;
  logic               w_a0_s2_rdy;
  logic               w_a1_s1_rdy;
  logic               w_a1_s2_rdy;

  // Both vectors come from registered state only, so a slot freed or woken
  // this cycle is seen by allocation / select one cycle later.
  assign w_free  = ~r_busy;
  assign w_ready = r_busy & r_s1_rdy & r_s2_rdy;

  // Scanning from the top down and shifting each hit into the "first" slot
  // leaves the lowest index in *_slot0 and the second-lowest in *_slot1.
  always_comb begin
    w_alloc_slot0 = c_no_slot;
    w_alloc_slot1 = c_no_slot;
    w_iss0_slot   = c_no_slot;
    w_iss1_slot   = c_no_slot;
    w_free_cnt    = 3'd0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_slot1 = w_alloc_slot0;
        w_alloc_slot0 = 3'(i);
      end
      if (w_ready[i]) begin
        w_iss1_slot = w_iss0_slot;
        w_iss0_slot = 3'(i);
      end
      w_free_cnt = w_free_cnt + {2'b00, w_free[i]};
    end
  end

  // All-or-nothing allocation; a lane-1-only request is rejected outright.
  assign w_need     = {1'b0, bus.a0_valid} + {1'b0, bus.a1_valid};
  assign w_alloc_ok = bus.rdy & ~bus.flush & ~(bus.a1_valid & ~bus.a0_valid)
                    & ({1'b0, w_need} <= w_free_cnt);
  assign w_wr0      = w_alloc_ok & bus.a0_valid;
  assign w_wr1      = w_alloc_ok & bus.a1_valid;

  // Same-cycle wakeup bypass into the allocating lanes.
  assign w_a0_s1_rdy = bus.a0_s1_rdy | (bus.wb_valid & (bus.a0_s1_tag == bus.wb_tag));
  assign w_a0_s2_rdy = bus.a0_s2_rdy | (bus.wb_valid & (bus.a0_s2_tag == bus.wb_tag));
  assign w_a1_s1_rdy = bus.a1_s1_rdy | (bus.wb_valid & (bus.a1_s1_tag == bus.wb_tag));
  assign w_a1_s2_rdy = bus.a1_s2_rdy | (bus.wb_valid & (bus.a1_s2_tag == bus.wb_tag));

  assign w_iss0_valid = (w_iss0_slot != c_no_slot) & bus.rdy & ~bus.flush;
  assign w_iss1_valid = (w_iss1_slot != c_no_slot) & bus.rdy & ~bus.flush;
  assign w_leave0     = w_iss0_valid & ~bus.iss0_stall;
  assign w_leave1     = w_iss1_valid & ~bus.iss1_stall;

  // Allocation only targets free slots while issue and wakeup only touch busy
  // ones, so the branches below never compete for the same slot. Flush wins
  // over the rdy enable so a mispredict is never lost while stalled. Tags
  // carry no reset: they are only looked at while the slot is busy.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_busy   <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
    end else if (bus.rdy) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (w_wr0 && (w_alloc_slot0 == 3'(i))) begin
          r_busy[i]   <= 1'b1;
          r_s1_tag[i] <= bus.a0_s1_tag;
          r_s2_tag[i] <= bus.a0_s2_tag;
          r_s1_rdy[i] <= w_a0_s1_rdy;
          r_s2_rdy[i] <= w_a0_s2_rdy;
        end else if (w_wr1 && (w_alloc_slot1 == 3'(i))) begin
          r_busy[i]   <= 1'b1;
          r_s1_tag[i] <= bus.a1_s1_tag;
          r_s2_tag[i] <= bus.a1_s2_tag;
          r_s1_rdy[i] <= w_a1_s1_rdy;
          r_s2_rdy[i] <= w_a1_s2_rdy;
        end else if ((w_leave0 && (w_iss0_slot == 3'(i))) ||
                     (w_leave1 && (w_iss1_slot == 3'(i)))) begin
          r_busy[i]   <= 1'b0;
          r_s1_rdy[i] <= 1'b0;
          r_s2_rdy[i] <= 1'b0;
        end else if (r_busy[i] && bus.wb_valid) begin
          if (r_s1_tag[i] == bus.wb_tag) r_s1_rdy[i] <= 1'b1;
          if (r_s2_tag[i] == bus.wb_tag) r_s2_rdy[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.alloc_ok    = w_alloc_ok;
  assign bus.alloc_slot0 = w_alloc_slot0;
  assign bus.alloc_slot1 = w_alloc_slot1;
  assign bus.iss0_valid  = w_iss0_valid;
  assign bus.iss1_valid  = w_iss1_valid;
  assign bus.iss0_slot   = w_iss0_slot;
  assign bus.iss1_slot   = w_iss1_slot;
  assign bus.free_cnt    = w_free_cnt;
  assign bus.full        = (w_free_cnt == 3'd0);

endmodule
`default_nettype wire
